mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if
//   Fetch / data / shared-memory bus bundle for mem_arbiter.
//   Rev 1.0 - initial release
// ============================================================================
`ifndef WORD
`define WORD 64
`endif

interface mem_arbiter_if;
    logic               f_req;
    logic [`WORD-1:0]   f_addr;
    logic               f_ready;
    logic [`WORD-1:0]   f_rdata;

    logic               d_req;
    logic               d_we;
    logic [`WORD-1:0]   d_addr;
    logic [`WORD-1:0]   d_wdata;
    logic               d_ready;
    logic [`WORD-1:0]   d_rdata;

    logic [`WORD-1:0]   mem_address;
    logic [`WORD-1:0]   mem_write_data;
    logic               mem_read;
    logic               mem_write;
    logic [`WORD-1:0]   mem_read_data;

    logic               busy;

    // Arbiter side: serves the two requesters and drives the memory strobes.
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
        output f_ready, f_rdata, d_ready, d_rdata,
        output mem_address, mem_write_data, mem_read, mem_write, busy
    );

    // Requester / memory side.
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
        input  f_ready, f_rdata, d_ready, d_rdata,
        input  mem_address, mem_write_data, mem_read, mem_write, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter
//   Shares one memory port between instruction fetch and the data stage.
//   Define MEM_ARB_RR_EN for round-robin arbitration (default: data priority).
//   Rev 1.0 - initial release
// ============================================================================
`ifndef WORD
`define WORD 64
`endif

module mem_arbiter #(
    parameter int LATENCY = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_arbiter_if.slave    bus
);

    localparam logic [1:0] C_IDLE     = 2'd0;
    localparam logic [1:0] C_BUSY     = 2'd1;
    localparam logic [1:0] C_RESP     = 2'd2;
    localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]         r_state;
    logic [3:0]         r_count;
    logic               r_owner_data;
    logic               r_we;
    logic [`WORD-1:0]   r_addr;
    logic [`WORD-1:0]   r_wdata;
    logic [`WORD-1:0]   r_f_rdata;
    logic [`WORD-1:0]   r_d_rdata;
    logic               w_any_req;
    logic               w_grant_data;

    assign w_any_req = bus.f_req | bus.d_req;

`ifdef MEM_ARB_RR_EN
    // Remembers whether the last grant went to data; reset value makes the
    // first tie go to data.
    logic r_last_data;

    always_comb begin
        w_grant_data = bus.d_req & (~bus.f_req | ~r_last_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_data <= 1'b0;
        end else if (r_state == C_IDLE && w_any_req) begin
            r_last_data <= w_grant_data;
        end
    end
`else
    always_comb begin
        w_grant_data = bus.d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= C_IDLE;
            r_count      <= 4'd0;
            r_owner_data <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= C_BUSY;
                        r_count      <= C_CNT_INIT;
                        r_owner_data <= w_grant_data;
                        r_we         <= w_grant_data & bus.d_we;
                        r_addr       <= w_grant_data ? bus.d_addr : bus.f_addr;
                        r_wdata      <= w_grant_data ? bus.d_wdata : '0;
                    end
                end
                C_BUSY: begin
                    if (r_count == 4'd0) begin
                        r_state <= C_RESP;
                        // Only the owner's read register sees the memory result.
                        if (!r_we) begin
                            if (r_owner_data) begin
                                r_d_rdata <= bus.mem_read_data;
                            end else begin
                                r_f_rdata <= bus.mem_read_data;
                            end
                        end
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                C_RESP: begin
                    r_state <= C_IDLE;
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = (r_state != C_IDLE);
    assign bus.mem_read       = (r_state == C_BUSY) & ~r_we;
    assign bus.mem_write      = (r_state == C_BUSY) &  r_we;
    assign bus.mem_address    = r_addr;
    assign bus.mem_write_data = r_wdata;
    assign bus.f_ready        = (r_state == C_RESP) & ~r_owner_data;
    assign bus.d_ready        = (r_state == C_RESP) &  r_owner_data;
    assign bus.f_rdata        = r_f_rdata;
    assign bus.d_rdata        = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: directed table, corner sequences and
//   randomized transactions against a transaction-level model.
//   Rev 1.0 - initial release
// ============================================================================
`ifndef WORD
`define WORD 64
`endif

module tb_mem_arbiter;

    localparam int W   = `WORD;
    localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic           f;
        logic           d;
        logic           we;
        logic [W-1:0]   fa;
        logic [W-1:0]   da;
        logic [W-1:0]   wd;
        logic [W-1:0]   mrd;
        logic           exp_data;
        logic [W-1:0]   exp_f;
        logic [W-1:0]   exp_d;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    logic [W-1:0] m_f;
    logic [W-1:0] m_d;
    logic         m_last_data;

    mem_arbiter_if bus ();

    mem_arbiter #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: who wins, and what each rdata holds after.
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        r = v;
        if (v.d && v.f) r.exp_data = RR ? ~m_last_data : 1'b1;
        else            r.exp_data = v.d;
        if (!r.exp_data)  m_f = v.mrd;
        else if (!v.we)   m_d = v.mrd;
        m_last_data = r.exp_data;
        r.exp_f = m_f;
        r.exp_d = m_d;
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        logic [W-1:0] ea;
        logic         ew;
        ea = v.exp_data ? v.da : v.fa;
        ew = v.exp_data & v.we;
        @(negedge clk);
        bus.f_req = v.f;   bus.d_req = v.d;   bus.d_we = v.we;
        bus.f_addr = v.fa; bus.d_addr = v.da; bus.d_wdata = v.wd;
        bus.mem_read_data = v.mrd;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("busy_in_access", bus.busy, 1);
            chk("mem_read", bus.mem_read, !ew);
            chk("mem_write", bus.mem_write, ew);
            chk("mem_address", bus.mem_address, ea);
            if (ew) chk("mem_write_data", bus.mem_write_data, v.wd);
            chk("ready_early", {bus.f_ready, bus.d_ready}, 0);
        end
        @(negedge clk);
        chk("f_ready_pulse", bus.f_ready, !v.exp_data);
        chk("d_ready_pulse", bus.d_ready, v.exp_data);
        chk("busy_resp", bus.busy, 1);
        chk("strobes_resp", {bus.mem_read, bus.mem_write}, 0);
        chk("f_rdata", bus.f_rdata, v.exp_f);
        chk("d_rdata", bus.d_rdata, v.exp_d);
        @(negedge clk);
        chk("busy_idle", bus.busy, 0);
        chk("ready_idle", {bus.f_ready, bus.d_ready}, 0);
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    vec_t tbl [6];
    vec_t rv;

    initial begin
        n_vec = 0; n_err = 0;
        m_f = '0; m_d = '0; m_last_data = 1'b0;
        reset = 1'b1;
        bus.f_req = 0; bus.d_req = 0; bus.d_we = 0;
        bus.f_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.mem_read_data = '0;

        // Directed table: three ties straight after reset, then single requests.
        tbl[0] = '{1, 1, 0, 64'h100, 64'h200, 64'h0, 64'h1111, 1, 64'h0, 64'h1111};
        tbl[1] = RR ? '{1, 1, 0, 64'h100, 64'h200, 64'h0, 64'h2222, 0, 64'h2222, 64'h1111}
                    : '{1, 1, 0, 64'h100, 64'h200, 64'h0, 64'h2222, 1, 64'h0,    64'h2222};
        tbl[2] = RR ? '{1, 1, 0, 64'h100, 64'h200, 64'h0, 64'h3333, 1, 64'h2222, 64'h3333}
                    : '{1, 1, 0, 64'h100, 64'h200, 64'h0, 64'h3333, 1, 64'h0,    64'h3333};
        tbl[3] = '{1, 0, 0, 64'h10, 64'h0, 64'h0, 64'hABCD, 0, 64'hABCD, 64'h3333};
        tbl[4] = '{0, 1, 1, 64'h0, 64'h20, 64'h55, 64'hDEAD, 1, 64'hABCD, 64'h3333};
        tbl[5] = '{0, 1, 0, 64'h0, 64'h30, 64'h0, 64'h77, 1, 64'hABCD, 64'h77};

        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_strobes", {bus.mem_read, bus.mem_write}, 0);
        chk("rst_ready", {bus.f_ready, bus.d_ready}, 0);
        chk("rst_f_rdata", bus.f_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_mem_write_data", bus.mem_write_data, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i]);
            m_f = tbl[i].exp_f; m_d = tbl[i].exp_d; m_last_data = tbl[i].exp_data;
        end

        // Fetch request dropped after the first busy cycle still completes.
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_addr = 64'h40; bus.mem_read_data = 64'h99;
        @(negedge clk);
        chk("drop_mem_read1", bus.mem_read, 1);
        bus.f_req = 1'b0;
        @(negedge clk);
        chk("drop_mem_read2", bus.mem_read, 1);
        @(negedge clk);
        chk("drop_f_ready", bus.f_ready, 1);
        chk("drop_f_rdata", bus.f_rdata, 64'h99);
        @(negedge clk);
        chk("drop_idle", {bus.busy, bus.f_ready}, 0);
        @(negedge clk);
        chk("drop_no_regrant", bus.busy, 0);
        m_f = 64'h99; m_last_data = 1'b0;

        for (int i = 0; i < 40; i++) begin
            rv.f  = 1'($urandom_range(0, 1));
            rv.d  = 1'($urandom_range(0, 1));
            rv.we = 1'($urandom_range(0, 1));
            rv.fa = {$urandom, $urandom};
            rv.da = {$urandom, $urandom};
            rv.wd = {$urandom, $urandom};
            rv.mrd = {$urandom, $urandom};
            rv.exp_data = 1'b0; rv.exp_f = '0; rv.exp_d = '0;
            if (!rv.f && !rv.d) begin
                @(negedge clk);
                chk("no_req_idle", bus.busy, 0);
            end else begin
                run_txn(predict(rv));
            end
        end

        // Reset in the second busy cycle abandons the access silently.
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_addr = 64'h80; bus.mem_read_data = 64'h5A5A;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.f_req = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {bus.mem_read, bus.mem_write}, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_ready", {bus.f_ready, bus.d_ready}, 0);
        chk("abort_f_rdata", bus.f_rdata, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_pulse", {bus.f_ready, bus.d_ready, bus.busy}, 0);
        end
        m_f = '0; m_d = '0; m_last_data = 1'b0;
        rv = '{1, 1, 0, 64'h900, 64'hA00, 64'h0, 64'hC0FFEE, 0, 64'h0, 64'h0};
        run_txn(predict(rv));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
